// File: rtl/clk_div_ramp_ctrl_pkg.sv
// clk_div_ramp_ctrl_pkg: shared state encoding and ramp direction constants.
package clk_div_ramp_ctrl_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/clk_div_ramp_ctrl_dwell_timer.sv
// clk_div_ramp_ctrl_dwell_timer: loadable down-counter with zero flag for per-code dwell.
module clk_div_ramp_ctrl_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic [DWELL_W-1:0] cnt,
    output logic               zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/clk_div_ramp_ctrl.sv
// clk_div_ramp_ctrl: ramps the divider select code one step per dwell period toward
// an accepted target, reporting busy while ramping and pulsing done on arrival.
module clk_div_ramp_ctrl
    import clk_div_ramp_ctrl_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [N-1:0]       req_code,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       x_out,
    output logic               busy,
    output logic               done
);
    state_t             state, state_n;
    logic [N-1:0]       target, target_n, x_n;
    logic [DWELL_W-1:0] dwell_lat, dwell_lat_n, load_val, dwell_cnt;
    logic               done_n, load, dec, zero, accept, dir;

    assign busy      = (state == ST_DWELL);
    assign req_ready = ~busy;
    assign accept    = req_valid && req_ready;
    assign dir       = (target > x_out) ? DIR_UP : DIR_DOWN;

    clk_div_ramp_ctrl_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .dec(dec),
        .cnt(dwell_cnt),
        .zero(zero)
    );

    always_comb begin
        state_n     = state;
        x_n         = x_out;
        done_n      = 1'b0;
        target_n    = target;
        dwell_lat_n = dwell_lat;
        load        = 1'b0;
        load_val    = dwell_lat;
        dec         = 1'b0;
        if (state == ST_IDLE) begin
            if (accept) begin
                target_n    = req_code;
                dwell_lat_n = dwell;
                if (req_code == x_out) begin
                    done_n = 1'b1;
                end else begin
                    state_n  = ST_DWELL;
                    load     = 1'b1;
                    load_val = dwell;
                end
            end
        end else if (!zero) begin
            dec = 1'b1;
        end else begin
            // Direction is chosen by comparison, so the step can never wrap.
            x_n = (dir == DIR_UP) ? x_out + 1'b1 : x_out - 1'b1;
            if (x_n == target) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_out     <= '0;
            done      <= 1'b0;
            target    <= '0;
            dwell_lat <= '0;
        end else begin
            state     <= state_n;
            x_out     <= x_n;
            done      <= done_n;
            target    <= target_n;
            dwell_lat <= dwell_lat_n;
        end
    end
endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// tb_clk_div_ramp_ctrl: directed vector table plus hand-written reset and busy-rejection sequences.
module tb_clk_div_ramp_ctrl;
    localparam int N       = 2;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [N-1:0]       req_code;
    logic [DWELL_W-1:0] dwell;
    logic [N-1:0]       x_out;
    logic               busy;
    logic               done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int start;
        int code;
        int dw;
        int exp_k;
        int exp_x;
    } vec_t;

    vec_t vecs[6];

    clk_div_ramp_ctrl #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_code(req_code),
        .dwell(dwell),
        .x_out(x_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int diff;
        int steps;
        int ex;
        diff = (v.code > v.start) ? v.code - v.start : v.start - v.code;
        chk("start_x", int'(x_out), v.start);
        req_valid = 1'b1;
        req_code  = v.code[N-1:0];
        dwell     = v.dw[DWELL_W-1:0];
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            steps = k / (v.dw + 1);
            if (steps > diff) steps = diff;
            ex = (v.code > v.start) ? v.start + steps : v.start - steps;
            chk("ramp_busy", int'(busy), 1);
            chk("ramp_ready", int'(req_ready), 0);
            chk("ramp_x", int'(x_out), ex);
            tick();
            k++;
        end
        chk("edges_to_done", k, v.exp_k);
        chk("final_x", int'(x_out), v.exp_x);
        chk("busy_at_done", int'(busy), 0);
        chk("done_high", int'(done), 1);
        tick();
        chk("done_pulse_end", int'(done), 0);
        chk("hold_x", int'(x_out), v.exp_x);
    endtask

    initial begin
        vecs[0] = '{start: 0, code: 3, dw: 2, exp_k: 9, exp_x: 3};
        vecs[1] = '{start: 3, code: 1, dw: 0, exp_k: 2, exp_x: 1};
        vecs[2] = '{start: 1, code: 2, dw: 3, exp_k: 4, exp_x: 2};
        vecs[3] = '{start: 2, code: 2, dw: 5, exp_k: 0, exp_x: 2};
        vecs[4] = '{start: 2, code: 0, dw: 1, exp_k: 4, exp_x: 0};
        vecs[5] = '{start: 0, code: 0, dw: 0, exp_k: 0, exp_x: 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_code  = '0;
        dwell     = '0;
        #1;
        chk("reset_x", int'(x_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_done", int'(done), 0);
        #11 rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Busy rejection: a held request for 0 must wait out the 0->3 ramp.
        req_valid = 1'b1;
        req_code  = 2'd3;
        dwell     = 8'd1;
        tick();
        req_code  = 2'd0;
        for (int k = 0; k < 6; k++) begin
            chk("rej_up_x", int'(x_out), k / 2);
            chk("rej_up_busy", int'(busy), 1);
            tick();
        end
        chk("rej_up_final", int'(x_out), 3);
        chk("rej_up_done", int'(done), 1);
        chk("rej_up_ready", int'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rej_dn_x", int'(x_out), 3 - k / 2);
            chk("rej_dn_busy", int'(busy), 1);
            chk("rej_dn_done", int'(done), 0);
            tick();
        end
        chk("rej_dn_final", int'(x_out), 0);
        chk("rej_dn_done_end", int'(done), 1);
        chk("rej_dn_idle", int'(busy), 0);
        tick();

        // Asynchronous reset mid-ramp, checked before any further clock edge.
        req_valid = 1'b1;
        req_code  = 2'd3;
        dwell     = 8'd0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_x", int'(x_out), 2);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_x", int'(x_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(req_ready), 1);
        chk("async_rst_done", int'(done), 0);
        #2 rst = 1'b0;
        run_vec('{start: 0, code: 1, dw: 0, exp_k: 1, exp_x: 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
